// File: rtl/cp0_regfile_if.sv
// mtc0/mfc0 access bus between the pipeline and the CP0 register file.
interface cp0_regfile_if;
  logic        we;
  logic [4:0]  waddr;
  logic [4:0]  raddr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, waddr, raddr, wdata, input rdata);
  modport slave  (input we, waddr, raddr, wdata, output rdata);
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file: Status/Cause/EPC/BadVAddr/Count/Compare, exception entry/eret, timer.
// Optional macro CP0_PRID_CONFIG_EN adds read-only PRId(15) and Config(16).
module cp0_regfile #(
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000,
  parameter int unsigned COUNT_DIV    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  cp0_regfile_if.slave         bus,
  input  logic [5:0]           int_i,
  input  logic [31:0]          except_type_i,
  input  logic [31:0]          pc_i,
  input  logic                 is_in_delayslot_i,
  input  logic [31:0]          badvaddr_i,
  output logic [31:0]          count_o,
  output logic [31:0]          compare_o,
  output logic [31:0]          status_o,
  output logic [31:0]          cause_o,
  output logic [31:0]          epc_o,
  output logic [31:0]          badvaddr_o,
  output logic                 timer_int_o
);

  localparam logic [4:0]  AddrBadVAddr = 5'd8;
  localparam logic [4:0]  AddrCount    = 5'd9;
  localparam logic [4:0]  AddrCompare  = 5'd11;
  localparam logic [4:0]  AddrStatus   = 5'd12;
  localparam logic [4:0]  AddrCause    = 5'd13;
  localparam logic [4:0]  AddrEpc      = 5'd14;
  localparam logic [31:0] StatusMask   = 32'h0000_FF03;
  localparam logic [31:0] CauseMask    = 32'h0000_0300;

  logic [31:0] count_q, count_d, compare_q, compare_d, status_q, status_d;
  logic [31:0] cause_q, cause_d, epc_q, epc_d, badvaddr_q, badvaddr_d;
  logic        div_q, div_d;
  logic        tick, exc, eret, sw_block, ti_set;
  logic [4:0]  exc_code;

  always_comb begin
    exc = 1'b0;
    case (except_type_i)
      32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'hd: exc = 1'b1;
      default: exc = 1'b0;
    endcase
  end

  assign eret     = (except_type_i == 32'he);
  assign sw_block = (except_type_i != 32'h0);
  assign exc_code = (except_type_i == 32'h1) ? 5'd0 : except_type_i[4:0];
  assign tick     = (COUNT_DIV == 1) || div_q;
  assign div_d    = (COUNT_DIV == 1) ? 1'b0 : ~div_q;
  assign ti_set   = (compare_q != 32'h0) && (count_q == compare_q);

  always_comb begin
    count_d    = tick ? count_q + 32'd1 : count_q;
    compare_d  = compare_q;
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    if (bus.we && bus.waddr == AddrCount) count_d = bus.wdata;
    if (bus.we && bus.waddr == AddrCompare) compare_d = bus.wdata;
    if (bus.we && !sw_block) begin
      if (bus.waddr == AddrStatus) status_d = (status_q & ~StatusMask) | (bus.wdata & StatusMask);
      if (bus.waddr == AddrCause) cause_d = (cause_q & ~CauseMask) | (bus.wdata & CauseMask);
      if (bus.waddr == AddrEpc) epc_d = bus.wdata;
    end

    if (exc) begin
      if (!status_q[1]) begin
        epc_d       = is_in_delayslot_i ? pc_i - 32'd4 : pc_i;
        cause_d[31] = is_in_delayslot_i;
      end
      status_d[1]   = 1'b1;
      cause_d[6:2]  = exc_code;
      if (except_type_i == 32'h4 || except_type_i == 32'h5) badvaddr_d = badvaddr_i;
    end else if (eret) begin
      status_d[1] = 1'b0;
    end

    // Compare write clears TI and beats a same-cycle match
    if (bus.we && bus.waddr == AddrCompare) cause_d[30] = 1'b0;
    else if (ti_set) cause_d[30] = 1'b1;
    cause_d[15:10] = {int_i[5] | cause_q[30], int_i[4:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= 32'h0;
      compare_q  <= 32'h0;
      status_q   <= RESET_STATUS;
      cause_q    <= 32'h0;
      epc_q      <= 32'h0;
      badvaddr_q <= 32'h0;
      div_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      div_q      <= div_d;
    end
  end

  always_comb begin
    bus.rdata = 32'h0;
    case (bus.raddr)
      AddrBadVAddr: bus.rdata = badvaddr_q;
      AddrCount:    bus.rdata = count_q;
      AddrCompare:  bus.rdata = compare_q;
      AddrStatus:   bus.rdata = status_q;
      AddrCause:    bus.rdata = cause_q;
      AddrEpc:      bus.rdata = epc_q;
`ifdef CP0_PRID_CONFIG_EN
      5'd15:        bus.rdata = 32'h0000_4220;
      5'd16:        bus.rdata = 32'h8000_8000;
`endif
      default:      bus.rdata = 32'h0;
    endcase
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign badvaddr_o  = badvaddr_q;
  assign timer_int_o = cause_q[30];

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: expectations queued at stimulus time, popped at sample time.
module tb_cp0_regfile;
  typedef enum int {SelData, SelCount, SelCompare, SelStatus, SelCause, SelEpc, SelBad,
                    SelTimer, SelFlag} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] mask;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  int_i = '0;
  logic [31:0] except_type_i = '0, pc_i = '0, badvaddr_i = '0;
  logic        is_in_delayslot_i = 1'b0;
  logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
  logic        timer_int_o;
  logic [31:0] flag;
  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];

  cp0_regfile_if bus_if();

  cp0_regfile dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus_if.slave),
    .int_i             (int_i),
    .except_type_i     (except_type_i),
    .pc_i              (pc_i),
    .is_in_delayslot_i (is_in_delayslot_i),
    .badvaddr_i        (badvaddr_i),
    .count_o           (count_o),
    .compare_o         (compare_o),
    .status_o          (status_o),
    .cause_o           (cause_o),
    .epc_o             (epc_o),
    .badvaddr_o        (badvaddr_o),
    .timer_int_o       (timer_int_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      SelData:    return bus_if.rdata;
      SelCount:   return count_o;
      SelCompare: return compare_o;
      SelStatus:  return status_o;
      SelCause:   return cause_o;
      SelEpc:     return epc_o;
      SelBad:     return badvaddr_o;
      SelTimer:   return {31'h0, timer_int_o};
      default:    return flag;
    endcase
  endfunction

  task automatic expect_val(input string tag, input sel_e s, input logic [31:0] mask,
                            input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = s; e.mask = mask; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel) & e.mask;
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s: got %h want %h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus_if.we = 1'b1; bus_if.waddr = a; bus_if.wdata = d;
    step();
    bus_if.we = 1'b0;
  endtask

  task automatic except_step(input logic [31:0] code, input logic [31:0] pc, input logic ds,
                             input logic [31:0] bad);
    except_type_i = code; pc_i = pc; is_in_delayslot_i = ds; badvaddr_i = bad;
    step();
    except_type_i = '0;
  endtask

  localparam logic [31:0] All = 32'hFFFF_FFFF;

  initial begin
    int n;
    logic [31:0] prid_exp;
    bus_if.we = 1'b0; bus_if.waddr = '0; bus_if.raddr = 5'd12; bus_if.wdata = '0;
    flag = '0;
    #1 rst = 1'b0;
    #1;
    expect_val("rst_status", SelStatus, All, 32'h0040_0000);
    expect_val("rst_count", SelCount, All, 32'h0);
    expect_val("rst_cause", SelCause, All, 32'h0);
    expect_val("rst_timer", SelTimer, All, 32'h0);
    expect_val("rst_rd_status", SelData, All, 32'h0040_0000);
    check_sb();

    rst = 1'b1;
    repeat (10) step();
    expect_val("idle_count", SelCount, All, 32'd5);
    expect_val("idle_status", SelStatus, All, 32'h0040_0000);
    expect_val("idle_cause", SelCause, All, 32'h0);
    expect_val("idle_timer", SelTimer, All, 32'h0);
    check_sb();

    // Old value visible during the write cycle
    bus_if.raddr = 5'd11;
    bus_if.we = 1'b1; bus_if.waddr = 5'd11; bus_if.wdata = 32'h20;
    #1;
    expect_val("rd_old_compare", SelData, All, 32'h0);
    check_sb();
    step();
    bus_if.we = 1'b0;
    expect_val("rd_new_compare", SelData, All, 32'h20);
    check_sb();
    mtc0(5'd9, 32'h1E);
    expect_val("count_load", SelCount, All, 32'h1E);
    check_sb();

    n = 0;
    while (timer_int_o !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    flag = {31'h0, (n >= 4 && n <= 5)};
    expect_val("ti_latency", SelFlag, All, 32'h1);
    expect_val("ti_cause30", SelCause, 32'h4000_0000, 32'h4000_0000);
    check_sb();
    step();
    expect_val("ti_ip7", SelCause, 32'h0000_8000, 32'h0000_8000);
    expect_val("ti_sticky", SelTimer, All, 32'h1);
    check_sb();
    mtc0(5'd11, 32'h100);
    expect_val("ti_clear", SelTimer, All, 32'h0);
    check_sb();
    step();

    except_step(32'h4, 32'hBFC0_0100, 1'b1, 32'h1234_5671);
    expect_val("adel_epc", SelEpc, All, 32'hBFC0_00FC);
    expect_val("adel_cause", SelCause, All, 32'h8000_0010);
    expect_val("adel_status", SelStatus, All, 32'h0040_0002);
    expect_val("adel_bad", SelBad, All, 32'h1234_5671);
    check_sb();

    except_step(32'h8, 32'h8000_0000, 1'b0, 32'h0);
    expect_val("nest_epc", SelEpc, All, 32'hBFC0_00FC);
    expect_val("nest_cause", SelCause, All, 32'h8000_0020);
    expect_val("nest_bad", SelBad, All, 32'h1234_5671);
    check_sb();

    except_step(32'he, 32'h0, 1'b0, 32'h0);
    expect_val("eret_status", SelStatus, All, 32'h0040_0000);
    expect_val("eret_epc", SelEpc, All, 32'hBFC0_00FC);
    expect_val("eret_cause", SelCause, All, 32'h8000_0020);
    check_sb();

    bus_if.we = 1'b1; bus_if.waddr = 5'd12; bus_if.wdata = 32'h0000_FF01;
    except_step(32'ha, 32'h0000_1000, 1'b0, 32'h0);
    bus_if.we = 1'b0;
    expect_val("prio_status", SelStatus, All, 32'h0040_0002);
    expect_val("prio_cause", SelCause, All, 32'h0000_0028);
    expect_val("prio_epc", SelEpc, All, 32'h0000_1000);
    check_sb();

    except_step(32'he, 32'h0, 1'b0, 32'h0);
    mtc0(5'd12, 32'hFFFF_FFFF);
    expect_val("status_mask", SelStatus, All, 32'h0040_FF03);
    check_sb();
    mtc0(5'd13, 32'hFFFF_FFFF);
    expect_val("cause_mask", SelCause, All, 32'h0000_0328);
    check_sb();
    mtc0(5'd8, 32'h0);
    expect_val("bad_ro", SelBad, All, 32'h1234_5671);
    check_sb();

    int_i = 6'h21;
    step();
    expect_val("int_sample", SelCause, All, 32'h0000_8728);
    check_sb();
    int_i = 6'h0;

    bus_if.raddr = 5'd3;
    #1;
    expect_val("rd_unlisted", SelData, All, 32'h0);
    check_sb();
`ifdef CP0_PRID_CONFIG_EN
    prid_exp = 32'h0000_4220;
`else
    prid_exp = 32'h0;
`endif
    bus_if.raddr = 5'd15;
    #1;
    expect_val("rd_prid", SelData, All, prid_exp);
    check_sb();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
